// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit between the MIPS core and a byte-lane data memory.
// Byte/half/word loads and stores, sign/zero extension, sub-word stores as
// read-modify-write, configurable read latency and endianness.
// Ports: core side req_* / resp_* (valid/ready request, one-cycle response),
// memory side mem_addr, mem_data_in, mem_data_out, mem_write_en.
module mips_lsu #(
    parameter int MEM_LAT    = 1,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            halted,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_data_in,
    input  logic [0:3][7:0] mem_data_out,
    output logic            mem_write_en
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [0:3][7:0] mem_data_in_q, mem_data_in_d;

    logic        accept;
    logic        misalign;
    logic [4:0]  pos;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] ext;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign req_ready    = rst_b && (state_q == IDLE) && !halted;
    assign accept       = req_valid && req_ready;
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = resp_valid ? rdata_q : 32'h0;
    assign resp_err     = resp_valid && err_q;
    assign mem_write_en = (state_q == WR);
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_data_in_q;
    assign rd_word      = mem_data_out;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // Bit position of the selected lane group inside the packed word.
    always_comb begin
        pos = 5'd0;
        case (size_q)
            2'd0:    pos = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
            2'd1:    pos = BIG_ENDIAN ? {~off_q[1], 4'b0000}
                                      : {off_q[1], 4'b0000};
            default: pos = 5'd0;
        endcase
    end

    always_comb begin
        rd_shift  = rd_word >> pos;
        ext       = rd_shift;
        lane_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'd0: begin
                ext       = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
                lane_mask = 32'h0000_00FF << pos;
            end
            2'd1: begin
                ext       = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
                lane_mask = 32'h0000_FFFF << pos;
            end
            default: begin
                ext       = rd_shift;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        merged = (rd_word & ~lane_mask) | ((wdata_q << pos) & lane_mask);
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        size_d        = size_q;
        signed_d      = signed_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = req_addr[1:0];
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = misalign;
                    if (misalign) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        cnt_d      = CNT_INIT;
                        if (req_write && req_size == 2'd2) begin
                            mem_data_in_d = req_wdata;
                            state_d       = WR;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        mem_data_in_d = merged;
                        state_d       = WR;
                    end else begin
                        rdata_d = ext;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            off_q         <= 2'd0;
            wdata_q       <= 32'h0;
            cnt_q         <= '0;
            rdata_q       <= 32'h0;
            err_q         <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed checks of mips_lsu with three instances
// (BE lat 1, LE lat 1, BE lat 3), each with its own word memory.
module tb_mips_lsu;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        halted;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic            valid [3];
    logic            rdy   [3];
    logic            rv    [3];
    logic [31:0]     rdata [3];
    logic            err   [3];
    logic [31:0]     ma    [3];
    logic [0:3][7:0] mdi   [3];
    logic [0:3][7:0] mdo   [3];
    logic            we    [3];

    logic [31:0] mem  [3][64];
    int          wcnt [3];

    int total = 0;
    int pass  = 0;

    always #5 clk = ~clk;

    mips_lsu #(.MEM_LAT(1), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_b(rst_b), .halted(halted),
        .req_valid(valid[0]), .req_ready(rdy[0]),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv[0]),
        .resp_rdata(rdata[0]), .resp_err(err[0]),
        .mem_addr(ma[0]), .mem_data_in(mdi[0]),
        .mem_data_out(mdo[0]), .mem_write_en(we[0])
    );

    mips_lsu #(.MEM_LAT(1), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_b(rst_b), .halted(halted),
        .req_valid(valid[1]), .req_ready(rdy[1]),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv[1]),
        .resp_rdata(rdata[1]), .resp_err(err[1]),
        .mem_addr(ma[1]), .mem_data_in(mdi[1]),
        .mem_data_out(mdo[1]), .mem_write_en(we[1])
    );

    mips_lsu #(.MEM_LAT(3), .BIG_ENDIAN(1'b1)) dut_l3 (
        .clk(clk), .rst_b(rst_b), .halted(halted),
        .req_valid(valid[2]), .req_ready(rdy[2]),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv[2]),
        .resp_rdata(rdata[2]), .resp_err(err[2]),
        .mem_addr(ma[2]), .mem_data_in(mdi[2]),
        .mem_data_out(mdo[2]), .mem_write_en(we[2])
    );

    assign mdo[0] = mem[0][ma[0][7:2]];
    assign mdo[1] = mem[1][ma[1][7:2]];
    assign mdo[2] = mem[2][ma[2][7:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i]) begin
                mem[i][ma[i][7:2]] <= mdi[i];
                wcnt[i] <= wcnt[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // One transaction on instance d; returns response cycle, write cycle,
    // read data, error flag and number of memory writes.
    task automatic run(input int d, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output int rc, output int wc,
                       output logic [31:0] rd, output logic er,
                       output int nw);
        int base;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rdy[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        valid[d]   = 1'b1;
        base       = wcnt[d];
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        rc = -1;
        wc = -1;
        rd = 32'h0;
        er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (we[d] && wc < 0) wc = c;
            if (rv[d]) begin
                rc = c;
                rd = rdata[d];
                er = err[d];
                break;
            end
        end
        nw = wcnt[d] - base;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] exp_be;
        logic [31:0] exp_le;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int rc, wc, nw;
        logic [31:0] rd;
        logic er;

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 64; j++) mem[i][j] = 32'h0;
            mem[i][4] = 32'h8899AABB;
            wcnt[i]   = 0;
            valid[i]  = 1'b0;
        end
        halted     = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rst_b      = 1'b0;

        vecs[0]  = '{0, 2'd0, 0, 32'h11, 32'h00000099, 32'h000000AA, 0, 2};
        vecs[1]  = '{0, 2'd0, 1, 32'h10, 32'hFFFFFF88, 32'hFFFFFFBB, 0, 2};
        vecs[2]  = '{0, 2'd1, 0, 32'h12, 32'h0000AABB, 32'h00008899, 0, 2};
        vecs[3]  = '{0, 2'd1, 1, 32'h12, 32'hFFFFAABB, 32'hFFFF8899, 0, 2};
        vecs[4]  = '{0, 2'd2, 0, 32'h10, 32'h8899AABB, 32'h8899AABB, 0, 2};
        vecs[5]  = '{0, 2'd0, 1, 32'h13, 32'hFFFFFFBB, 32'hFFFFFF88, 0, 2};
        vecs[6]  = '{0, 2'd1, 0, 32'h10, 32'h00008899, 32'h0000AABB, 0, 2};
        vecs[7]  = '{0, 2'd2, 0, 32'h12, 32'h0, 32'h0, 1, 1};
        vecs[8]  = '{0, 2'd1, 1, 32'h11, 32'h0, 32'h0, 1, 1};
        vecs[9]  = '{1, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1};
        vecs[10] = '{0, 2'd0, 0, 32'h12, 32'h000000AA, 32'h00000099, 0, 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, rdy[0]}, 32'h0);
        chk("rst_resp_valid", {31'b0, rv[0]}, 32'h0);
        chk("rst_mem_addr", ma[0], 32'h0);
        chk("rst_we", {31'b0, we[0]}, 32'h0);
        rst_b = 1'b1;
        #1;
        chk("ready_after_rst", {31'b0, rdy[0]}, 32'h1);

        // Table: loads and error cases on BE and LE instances
        foreach (vecs[k]) begin
            for (int d = 0; d < 2; d++) begin
                run(d, vecs[k].w, vecs[k].sz, vecs[k].sg, vecs[k].a,
                    32'h12345678, rc, wc, rd, er, nw);
                chk($sformatf("v%0d_d%0d_cyc", k, d), rc, vecs[k].exp_cyc);
                chk($sformatf("v%0d_d%0d_rdata", k, d), rd,
                    d == 0 ? vecs[k].exp_be : vecs[k].exp_le);
                chk($sformatf("v%0d_d%0d_err", k, d), {31'b0, er},
                    {31'b0, vecs[k].exp_err});
                chk($sformatf("v%0d_d%0d_nwr", k, d), nw, 0);
            end
        end

        // sb with MEM_LAT=3: write in C4, response in C5
        run(2, 1, 2'd0, 0, 32'h13, 32'h12345677, rc, wc, rd, er, nw);
        chk("sb_l3_wcyc", wc, 4);
        chk("sb_l3_rcyc", rc, 5);
        chk("sb_l3_nwr", nw, 1);
        chk("sb_l3_rdata", rd, 32'h0);
        chk("sb_l3_mem", mem[2][4], 32'h8899AA77);

        // lw on MEM_LAT=3 sees the merged word, response in C4
        run(2, 0, 2'd2, 0, 32'h10, 32'h0, rc, wc, rd, er, nw);
        chk("lw_l3_rcyc", rc, 4);
        chk("lw_l3_rdata", rd, 32'h8899AA77);

        // sw: write in C1, response in C2
        run(0, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF, rc, wc, rd, er, nw);
        chk("sw_wcyc", wc, 1);
        chk("sw_rcyc", rc, 2);
        chk("sw_mem", mem[0][8], 32'hDEADBEEF);
        chk("sw_rdata", rd, 32'h0);

        // LE sh at offset 0 lands in bits 15:0
        run(1, 1, 2'd1, 0, 32'h10, 32'h1234CAFE, rc, wc, rd, er, nw);
        chk("sh_le_wcyc", wc, 2);
        chk("sh_le_rcyc", rc, 3);
        chk("sh_le_mem", mem[1][4], 32'h8899CAFE);

        // Reset during RD_WAIT of an sh on MEM_LAT=3
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000BEEF;
        valid[2]   = 1'b1;
        nw         = wcnt[2];
        @(posedge clk);
        #1;
        valid[2] = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, rdy[2]}, 32'h0);
        chk("mid_rst_we", {31'b0, we[2]}, 32'h0);
        chk("mid_rst_addr", ma[2], 32'h0);
        chk("mid_rst_resp", {31'b0, rv[2]}, 32'h0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rst_nowrite", wcnt[2] - nw, 0);
        chk("mid_rst_mem", mem[2][8], 32'h0);
        run(2, 0, 2'd2, 0, 32'h10, 32'h0, rc, wc, rd, er, nw);
        chk("post_rst_lw_cyc", rc, 4);
        chk("post_rst_lw_rdata", rd, 32'h8899AA77);

        // halted raised during a load; held request waits for halted=0
        @(negedge clk);
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        valid[0]   = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h20;
        @(negedge clk);
        halted = 1'b1;
        @(negedge clk);
        chk("halt_resp_valid", {31'b0, rv[0]}, 32'h1);
        chk("halt_resp_rdata", rdata[0], 32'h8899AABB);
        rc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rdy[0] || rv[0]) rc++;
        end
        chk("halt_blocked", rc, 0);
        halted = 1'b0;
        #1;
        chk("unhalt_ready", {31'b0, rdy[0]}, 32'h1);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        rc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rv[0] && rc < 0) begin
                rc = c;
                rd = rdata[0];
            end
        end
        chk("unhalt_lw_cyc", rc, 2);
        chk("unhalt_lw_rdata", rd, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Parametrised load/store unit that sits between the MIPS core datapath and the byte-lane data memory port. It generalises the core's direct word-only memory hookup. It adds byte, halfword and word accesses with sign or zero extension, configurable memory read latency, and selectable endianness. Sub-word stores are done as read-modify-write, because the memory has a single write enable. A one-request-at-a-time valid/ready handshake towards the core and a misalignment error response complete the block.

Parameters:
MEM_LAT, 1, number of rising edges from mem_addr driven to read data sampled; must be >= 1 (1 = asynchronous-read memory)
BIG_ENDIAN, 1, 1: byte offset k maps to word bits [31-8k -: 8]; 0: offset k maps to bits [8k +: 8]

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous active-low reset
halted  input  1  core halted; blocks acceptance of new requests
req_valid  input  1  core request valid
req_ready  output  1  LSU can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  input  1  load result sign-extends (1) or zero-extends (0)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned or illegal size, qualified by resp_valid
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_data_in  output  8 x [0:3]  write data lanes; word value = {lane0,lane1,lane2,lane3}
mem_data_out  input  8 x [0:3]  read data lanes, same packing
mem_write_en  output  1  memory write strobe

Behaviour:
- Reset (async, rst_b=0): state IDLE; all outputs 0 (req_ready=0 while in reset); any in-flight access is abandoned and no write is issued.
- req_ready = (state==IDLE) && !halted. A request is accepted on a rising edge where req_valid && req_ready. All request fields are registered at acceptance; later changes on req_* are ignored.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 3.
  - Goes to RESP in the next cycle with resp_err=1 and resp_rdata=0.
  - No memory access; mem_write_en stays 0.
- Cycle numbering: E0 = acceptance edge, Cn = the cycle after edge En.
- States: IDLE, RD_WAIT, WR, RESP.
- Load: IDLE -> RD_WAIT.
  - mem_addr driven from C1.
  - A down-counter initialised to MEM_LAT-1; mem_data_out is sampled at edge E_MEM_LAT.
  - RESP in C_(MEM_LAT+1).
- Word store: IDLE -> WR.
  - C1: mem_addr, mem_data_in = wdata, mem_write_en=1.
  - RESP in C2.
- Sub-word store: IDLE -> RD_WAIT (read as for a load) -> WR.
  - WR in C_(MEM_LAT+1): merged word written, mem_write_en=1.
  - Merge: selected byte or half lanes take wdata[7:0] or wdata[15:0]; other lanes keep the read data.
  - RESP in C_(MEM_LAT+2).
- Extraction:
  - Byte: offset = addr[1:0], bit placement per BIG_ENDIAN.
  - Half: offset addr[1]. BE: offset 0 -> bits 31:16, offset 2 -> bits 15:0. LE: reversed.
  - Extended to 32 bits per req_signed; a word load returns the packed word unchanged.
- RESP lasts exactly one cycle: resp_valid=1, then IDLE. There is no backpressure on the response.
- resp_rdata and resp_err are valid only while resp_valid=1 and are 0 otherwise.
- mem_write_en is high only in WR, for exactly one cycle per store.
- mem_addr and mem_data_in hold their last values outside an access (0 after reset).
- halted asserting mid-transaction: the transaction completes normally, and no new request is accepted until halted=0.
- Back-to-back requests: the earliest next acceptance is the edge after the RESP cycle, so the minimum issue interval is latency + 1.

Test Plan:
1. MEM_LAT=1, BE. Memory word @0x10 = 0x8899AABB; lbu 0x11 -> resp_valid in C2, rdata 0x00000099; lb 0x10 -> 0xFFFFFF88.
2. BE, lhu 0x12 -> 0x0000AABB. LE instance, lh 0x12 -> 0xFFFF8899; lw 0x10 -> 0x8899AABB in both modes.
3. BE, sb 0x13 wdata 0x12345677 onto 0x8899AABB, MEM_LAT=3 -> mem_write_en only in C4 with word 0x8899AA77; resp_valid in C5.
4. sw 0x20 0xDEADBEEF -> mem_write_en in C1, resp_valid in C2. lw 0x22 -> resp_err=1 in C1, no write. Size 3 -> err.
5. Assert rst_b=0 during RD_WAIT of an sh -> outputs immediately 0, no mem_write_en ever; after release a new lw completes normally.
6. Raise halted during a load -> the load completes; req_ready stays 0 and a held req_valid is not accepted until halted falls.
